// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the CPU memory bus between instruction fetch (m0) and load/store (m1).
// Optional macro CPU_ARBITER_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority to m1.
module cpu_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_m0_request,
  input  logic          i_m0_rw,
  input  logic [AW-1:0] i_m0_address,
  input  logic [DW-1:0] i_m0_wdata,
  output logic [DW-1:0] o_m0_rdata,
  output logic          o_m0_ready,
  input  logic          i_m1_request,
  input  logic          i_m1_rw,
  input  logic [AW-1:0] i_m1_address,
  input  logic [DW-1:0] i_m1_wdata,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_m1_ready,
  output logic          o_bus_request,
  output logic          o_bus_rw,
  output logic [AW-1:0] o_bus_address,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          win;
  logic          bus_request_q, bus_request_d;
  logic          bus_rw_q, bus_rw_d;
  logic [AW-1:0] bus_address_q, bus_address_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;

`ifdef CPU_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // A tie goes to the master that was not served last; reset value 1 lets m0 win first.
  always_comb begin
    win = i_m1_request;
    if (i_m0_request && i_m1_request) win = ~last_grant_q;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_IDLE && (i_m0_request || i_m1_request)) last_grant_d = win;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) last_grant_q <= 1'b1;
    else         last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    win = i_m1_request;
  end
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    bus_request_d = bus_request_q;
    bus_rw_d      = bus_rw_q;
    bus_address_d = bus_address_q;
    bus_wdata_d   = bus_wdata_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    m0_ready_d    = 1'b0;
    m1_ready_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_m0_request || i_m1_request) begin
          grant_d       = win;
          bus_request_d = 1'b1;
          bus_rw_d      = win ? i_m1_rw      : i_m0_rw;
          bus_address_d = win ? i_m1_address : i_m0_address;
          bus_wdata_d   = win ? i_m1_wdata   : i_m0_wdata;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_bus_ready) begin
          if (grant_q) begin
            m1_rdata_d = i_bus_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = i_bus_rdata;
            m0_ready_d = 1'b1;
          end
          bus_request_d = 1'b0;
          bus_rw_d      = 1'b0;
          bus_address_d = '0;
          bus_wdata_d   = '0;
          state_d       = ST_RELEASE;
        end
      end
      // Requests are not sampled here, giving the served master a cycle to drop its request.
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= '0;
      bus_wdata_q   <= '0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      bus_request_q <= bus_request_d;
      bus_rw_q      <= bus_rw_d;
      bus_address_q <= bus_address_d;
      bus_wdata_q   <= bus_wdata_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      m0_ready_q    <= m0_ready_d;
      m1_ready_q    <= m1_ready_d;
    end
  end

  assign o_bus_request = bus_request_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_address_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_m0_rdata    = m0_rdata_q;
  assign o_m0_ready    = m0_ready_q;
  assign o_m1_rdata    = m1_rdata_q;
  assign o_m1_ready    = m1_ready_q;

endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Two-master arbiter that shares the single CPU memory bus between instruction fetch (master 0) and load/store (master 1). It sits between the pipeline stages and the bus; the ready pulses it returns drive the stall (`busy`) inputs of the stage skid buffers. One transaction is in flight at a time. Bus request and transaction fields are registered and held stable for the whole transaction.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `i_clock`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_m0_request`  in  1  fetch request; held high until `o_m0_ready`.
- `i_m0_rw`  in  1  1 = write, 0 = read.
- `i_m0_address`  in  AW  address.
- `i_m0_wdata`  in  DW  write data.
- `o_m0_rdata`  out  DW  read data; valid while `o_m0_ready` = 1.
- `o_m0_ready`  out  1  one-cycle completion pulse.
- `i_m1_*` / `o_m1_*`: identical set for load/store.
- `o_bus_request`  out  1  bus transaction request.
- `o_bus_rw`  out  1  direction of the granted transaction.
- `o_bus_address`  out  AW  address of the granted transaction.
- `o_bus_wdata`  out  DW  write data of the granted transaction.
- `i_bus_rdata`  in  DW  bus read data.
- `i_bus_ready`  in  1  bus completion, sampled only in BUSY.

## Operation
- States:
  - IDLE.
  - BUSY (with registered `grant` bit: 0 = m0, 1 = m1).
  - RELEASE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both requesting: winner per Configuration.
  - On grant, register `rw`, `address` and `wdata` of the winner onto the bus outputs, set `o_bus_request` = 1, set `grant`, update `last_grant` = `grant`, and go to BUSY.
- BUSY:
  - Bus outputs are held constant. Master input changes are ignored.
  - On sampled `i_bus_ready` = 1: register `i_bus_rdata` into `o_mX_rdata` of the granted master and set that master's `o_mX_ready` = 1. Clear `o_bus_request`, `o_bus_rw`, `o_bus_address` and `o_bus_wdata` to 0. Go to RELEASE.
- RELEASE:
  - Lasts exactly one cycle; `o_mX_ready` is high during this cycle only.
  - The served master must drop or replace its request in this cycle. Requests are not sampled here.
  - Next state is IDLE.
- `o_mX_rdata` holds its last value after the pulse. Write transactions also load `i_bus_rdata`, which is don't-care.
- The non-granted master's ready output stays 0 throughout.
- `i_bus_ready` in IDLE or RELEASE is ignored.

Reset, asserted at any time including mid-transaction:
- state = IDLE, `last_grant` = 1.
- Every output is 0: `o_bus_*`, `o_m0_ready`, `o_m1_ready`, `o_m0_rdata`, `o_m1_rdata`.
- An abandoned bus transaction is not completed.

## Timing
- Grant latency: a request sampled in IDLE at edge E gives `o_bus_request` = 1 from E.
- Completion latency: `i_bus_ready` sampled at edge R gives `o_mX_ready` = 1 and `o_bus_request` = 0 from R, for one cycle.
- The state is IDLE after edge R+1. The earliest next grant is at edge R+2.
- Minimum spacing between bus requests: 2 cycles with `o_bus_request` low.
- Zero-wait bus (ready in the first BUSY cycle): a transaction occupies 3 cycles (BUSY, RELEASE, IDLE).
- No combinational paths from any input to any output.

## Configuration
- `CPU_ARBITER_ROUND_ROBIN_EN`:
  - Defined: on a simultaneous request, grant the master opposite to `last_grant`. After reset m0 wins the first tie; winners then alternate m0, m1, m0, …
  - Undefined: fixed priority. m1 (load/store) always wins a tie and `last_grant` is unused. m0 can starve under continuous m1 requests, which is accepted.
- A single requester is granted identically in both builds.

## Test plan
- Reset, then m0 reads 0x100 with the bus returning 0xDEADBEEF after 2 wait cycles:
  - `o_bus_request` = 1 one cycle after the request, with `o_bus_address` = 0x100 and `o_bus_rw` = 0.
  - `o_m0_ready` pulses for exactly one cycle with `o_m0_rdata` = 0xDEADBEEF.
  - `o_m1_ready` stays 0.
- m1 writes 0x55AA to 0x2000 while m0 changes its address mid-transaction:
  - Bus fields stay 0x2000 / 0x55AA / `rw` = 1 until `i_bus_ready`.
  - `o_m1_ready` pulses once.
- Both masters request continuously for 4 transactions with a zero-wait bus:
  - With `CPU_ARBITER_ROUND_ROBIN_EN`: grant order m0, m1, m0, m1.
  - Without it: m1, m1, m1, m1.
  - In both builds, each transaction spans 3 cycles.
- `i_bus_ready` pulsed while in IDLE and in RELEASE: no ready output and no state change.
- `i_reset` asserted during BUSY with `o_bus_request` = 1:
  - All outputs read 0 immediately, without waiting for a clock edge.
  - After release, a new m1 request is granted normally.
  - In the round-robin build, the first tie after reset goes to m0.
